// File: rtl/obi_mux_rr_if.sv
// OBI bundle for the N:1 round-robin mux: N upstream request/response
// channels plus the single shared downstream channel.
// slave  : the mux's view (takes upstream requests, drives the downstream port)
// master : the environment's view (upstream managers plus downstream target)
interface obi_mux_rr_if #(
  parameter int unsigned NumSbrPorts = 2,
  parameter int unsigned AddrW       = 32,
  parameter int unsigned DataW       = 32,
  parameter int unsigned IdW         = 4
);
  localparam int unsigned BeW = DataW / 8;

  // upstream A channel
  logic [NumSbrPorts-1:0]            sbr_req;
  logic [NumSbrPorts-1:0][AddrW-1:0] sbr_addr;
  logic [NumSbrPorts-1:0]            sbr_we;
  logic [NumSbrPorts-1:0][BeW-1:0]   sbr_be;
  logic [NumSbrPorts-1:0][DataW-1:0] sbr_wdata;
  logic [NumSbrPorts-1:0][IdW-1:0]   sbr_aid;
  // upstream grant and R channel
  logic [NumSbrPorts-1:0]            sbr_gnt;
  logic [NumSbrPorts-1:0]            sbr_rvalid;
  logic [NumSbrPorts-1:0][DataW-1:0] sbr_rdata;
  logic [NumSbrPorts-1:0][IdW-1:0]   sbr_rid;
  logic [NumSbrPorts-1:0]            sbr_err;
  // downstream port
  logic             mgr_req;
  logic [AddrW-1:0] mgr_addr;
  logic             mgr_we;
  logic [BeW-1:0]   mgr_be;
  logic [DataW-1:0] mgr_wdata;
  logic [IdW-1:0]   mgr_aid;
  logic             mgr_gnt;
  logic             mgr_rvalid;
  logic [DataW-1:0] mgr_rdata;
  logic [IdW-1:0]   mgr_rid;
  logic             mgr_err;

  modport slave (
    input  sbr_req, sbr_addr, sbr_we, sbr_be, sbr_wdata, sbr_aid,
    output sbr_gnt, sbr_rvalid, sbr_rdata, sbr_rid, sbr_err,
    output mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata, mgr_aid,
    input  mgr_gnt, mgr_rvalid, mgr_rdata, mgr_rid, mgr_err
  );

  modport master (
    output sbr_req, sbr_addr, sbr_we, sbr_be, sbr_wdata, sbr_aid,
    input  sbr_gnt, sbr_rvalid, sbr_rdata, sbr_rid, sbr_err,
    input  mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata, mgr_aid,
    output mgr_gnt, mgr_rvalid, mgr_rdata, mgr_rid, mgr_err
  );
endinterface

// File: rtl/obi_mux_rr.sv
// obi_mux_rr: N:1 OBI multiplexer with round-robin A-channel arbitration
// and in-order R-channel routing through a FIFO of granted port indices.
// A and R paths are purely combinational; only arbitration state, the
// index FIFO and the outstanding counter are registered.
// Optional feature macro OBI_MUX_RR_SPURIOUS_ERR_EN adds a sticky
// spurious_rsp_o flag raised by any rvalid arriving with nothing outstanding.
// NumSbrPorts must match the NumSbrPorts of the connected interface.
module obi_mux_rr #(
  parameter  int unsigned NumSbrPorts = 2,
  parameter  int unsigned NumMaxTrans = 4,
  localparam int unsigned IdxW        = $clog2(NumSbrPorts),
  localparam int unsigned CntW        = $clog2(NumMaxTrans + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  obi_mux_rr_if.slave     bus,
`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
  output logic            spurious_rsp_o,
`endif
  output logic [CntW-1:0] outstanding_o
);

  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;

  logic [IdxW-1:0] r_rr_ptr;
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_fifo [NumMaxTrans];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;

  logic            w_any_req;
  logic            w_locked;
  logic [IdxW-1:0] w_win;
  logic [IdxW-1:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_req_o;

  // Winner selection: a stalled request keeps its port, else first requester at or after the pointer.
  always_comb begin
    int unsigned v_idx;
    logic        v_found;
    v_idx     = 0;
    v_found   = 1'b0;
    w_any_req = |bus.sbr_req;
    w_locked  = r_lock & bus.sbr_req[r_lock_idx];
    w_win     = r_rr_ptr;
    if (w_locked) begin
      w_win = r_lock_idx;
    end else begin
      for (int unsigned k = 0; k < NumSbrPorts; k++) begin
        v_idx = 32'(r_rr_ptr) + k;
        if (v_idx >= NumSbrPorts) v_idx = v_idx - NumSbrPorts;
        if (!v_found && bus.sbr_req[IdxW'(v_idx)]) begin
          v_found = 1'b1;
          w_win   = IdxW'(v_idx);
        end
      end
    end
  end

  // A channel forwarding; a full FIFO only lets a request through when a response frees a slot this cycle.
  always_comb begin
    w_full    = (r_cnt == CntW'(NumMaxTrans));
    w_empty   = (r_cnt == '0);
    w_pop     = bus.mgr_rvalid & ~w_empty;
    w_req_o   = w_any_req & (~w_full | w_pop) & ~rst_i;
    w_push    = w_req_o & bus.mgr_gnt;
    bus.mgr_req   = w_req_o;
    bus.mgr_addr  = bus.sbr_addr[w_win];
    bus.mgr_we    = bus.sbr_we[w_win];
    bus.mgr_be    = bus.sbr_be[w_win];
    bus.mgr_wdata = bus.sbr_wdata[w_win];
    bus.mgr_aid   = bus.sbr_aid[w_win];
  end

  // Grant goes to the winner only; rvalid goes to the oldest granted port; R payload is broadcast.
  always_comb begin
    w_head         = r_fifo[r_rd_ptr];
    bus.sbr_gnt    = '0;
    bus.sbr_rvalid = '0;
    bus.sbr_rdata  = '0;
    bus.sbr_rid    = '0;
    bus.sbr_err    = '0;
    for (int unsigned i = 0; i < NumSbrPorts; i++) begin
      bus.sbr_gnt[i]    = w_push & (w_win == IdxW'(i));
      bus.sbr_rvalid[i] = w_pop & (w_head == IdxW'(i));
      bus.sbr_rdata[i]  = bus.mgr_rdata;
      bus.sbr_rid[i]    = bus.mgr_rid;
      bus.sbr_err[i]    = bus.mgr_err;
    end
  end

  // Arbitration state: advance the pointer past the winner on handshake, hold the winner while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_win == IdxW'(NumSbrPorts - 1)) ? '0 : w_win + IdxW'(1);
      r_lock   <= 1'b0;
    end else if (w_req_o) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_win;
    end else if (r_lock && !bus.sbr_req[r_lock_idx]) begin
      r_lock <= 1'b0;
    end
  end

  // Index FIFO storage; contents are only read while the count is non-zero, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_win;
  end

  // FIFO pointers (wrap at depth, any depth) and outstanding count; push and pop may coincide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PtrW'(NumMaxTrans - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PtrW'(NumMaxTrans - 1)) ? '0 : r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop && !w_full)      r_cnt <= r_cnt + CntW'(1);
      else if (w_pop && !w_push && !w_empty) r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign outstanding_o = r_cnt;

`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
  logic r_spurious;

  // Sticky flag for a response that arrived with no transaction outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          r_spurious <= 1'b0;
    else if (bus.mgr_rvalid && w_empty) r_spurious <= 1'b1;
  end

  assign spurious_rsp_o = r_spurious;
`endif

endmodule

// File: tb/tb_obi_mux_rr.sv
// Testbench for obi_mux_rr (4 ports, 3 outstanding): a directed vector
// table, hand-written lock/full/reset sequences, then random traffic
// checked against a queue-based model of the mux rules.
module tb_obi_mux_rr;
  localparam int unsigned N    = 4;
  localparam int unsigned D    = 3;
  localparam int unsigned CntW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CntW-1:0] outstanding;
`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
  logic            spur;
`endif

  obi_mux_rr_if #(.NumSbrPorts(N)) bus ();

  obi_mux_rr #(.NumSbrPorts(N), .NumMaxTrans(D)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
    .spurious_rsp_o(spur),
`endif
    .outstanding_o (outstanding)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      bus.sbr_addr[i]  = 32'h100 + 32'(i * 16);
      bus.sbr_wdata[i] = 32'(i);
      bus.sbr_aid[i]   = 4'(i);
    end
    bus.sbr_req    = '0;
    bus.sbr_we     = '0;
    bus.sbr_be     = '1;
    bus.mgr_gnt    = 1'b0;
    bus.mgr_rvalid = 1'b0;
    bus.mgr_rdata  = '0;
    bus.mgr_rid    = '0;
    bus.mgr_err    = 1'b0;
  endtask

  // Holds reset over a clock edge with active requests, then releases it just after a posedge.
  task automatic do_reset();
    idle_inputs();
    rst            = 1'b1;
    bus.sbr_req    = '1;
    bus.mgr_gnt    = 1'b1;
    bus.mgr_rvalid = 1'b1;
    @(negedge clk);
    chk("rst req_o", 64'(bus.mgr_req), 64'(0));
    chk("rst gnt", 64'(bus.sbr_gnt), 64'(0));
    chk("rst rvalid", 64'(bus.sbr_rvalid), 64'(0));
    chk("rst outstanding", 64'(outstanding), 64'(0));
`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
    chk("rst spurious", 64'(spur), 64'(0));
`endif
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]      req;
    logic            gnt;
    logic            rv;
    logic            ro;
    logic [3:0]      gv;
    logic [3:0]      rvv;
    logic [CntW-1:0] cnt;
    logic [31:0]     addr;
  } vec_t;

  vec_t tbl [15];

  // random-phase model state
  int          q[$];
  int          m_ptr;
  bit          m_lock;
  int          m_lock_idx;
  bit          m_spur;
  bit          pend [N];
  logic [31:0] paddr [N];

  initial begin
    // req, gnt, rvalid | req_o, gnt vec, rvalid vec, outstanding, addr
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 32'h100};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 2'd0, 32'h100};
    tbl[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, 32'h0};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 2'd1, 32'h0};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 32'h0};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 2'd0, 32'h110};
    tbl[6]  = '{4'b1101, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 2'd1, 32'h120};
    tbl[7]  = '{4'b1001, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 2'd2, 32'h130};
    tbl[8]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3, 32'h0};
    tbl[9]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0010, 2'd3, 32'h100};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 2'd3, 32'h0};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 2'd2, 32'h0};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 2'd1, 32'h0};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 32'h0};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 32'h0};

    do_reset();

    // ---- directed table ----
    for (int v = 0; v < 15; v++) begin
      bus.sbr_req    = tbl[v].req;
      bus.mgr_gnt    = tbl[v].gnt;
      bus.mgr_rvalid = tbl[v].rv;
      bus.mgr_rdata  = 32'hD000 + 32'(v);
      @(negedge clk);
      chk($sformatf("vec%0d req_o", v), 64'(bus.mgr_req), 64'(tbl[v].ro));
      if (tbl[v].ro) chk($sformatf("vec%0d addr", v), 64'(bus.mgr_addr), 64'(tbl[v].addr));
      chk($sformatf("vec%0d gnt", v), 64'(bus.sbr_gnt), 64'(tbl[v].gv));
      chk($sformatf("vec%0d rvalid", v), 64'(bus.sbr_rvalid), 64'(tbl[v].rvv));
      chk($sformatf("vec%0d outstanding", v), 64'(outstanding), 64'(tbl[v].cnt));
      if (tbl[v].rvv != 0) chk($sformatf("vec%0d rdata", v), 64'(bus.sbr_rdata[3]), 64'(32'hD000 + 32'(v)));
      next_cycle();
    end
    bus.mgr_rvalid = 1'b0;
`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
    @(negedge clk);
    chk("spurious sticky", 64'(spur), 64'(1));
    next_cycle();
`endif

    // ---- stall / lock: P2 stalled, P0 arrives meanwhile ----
    do_reset();
    bus.sbr_req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) bus.sbr_req[0] = 1'b1;
      @(negedge clk);
      chk($sformatf("lock c%0d req_o", c), 64'(bus.mgr_req), 64'(1));
      chk($sformatf("lock c%0d addr", c), 64'(bus.mgr_addr), 64'(32'h120));
      chk($sformatf("lock c%0d gnt", c), 64'(bus.sbr_gnt), 64'(0));
      next_cycle();
    end
    bus.mgr_gnt = 1'b1;
    @(negedge clk);
    chk("lock release gnt", 64'(bus.sbr_gnt), 64'(4'b0100));
    chk("lock release addr", 64'(bus.mgr_addr), 64'(32'h120));
    next_cycle();
    bus.sbr_req[2] = 1'b0;
    @(negedge clk);
    chk("after lock gnt", 64'(bus.sbr_gnt), 64'(4'b0001));
    chk("after lock addr", 64'(bus.mgr_addr), 64'(32'h100));
    next_cycle();

    // ---- full, then response and new request in the same cycle ----
    bus.sbr_req = 4'b0010;
    @(negedge clk);
    chk("fill gnt", 64'(bus.sbr_gnt), 64'(4'b0010));
    chk("fill outstanding", 64'(outstanding), 64'(2));
    next_cycle();
    bus.sbr_req = 4'b1000;
    @(negedge clk);
    chk("full req_o", 64'(bus.mgr_req), 64'(0));
    chk("full gnt", 64'(bus.sbr_gnt), 64'(0));
    chk("full outstanding", 64'(outstanding), 64'(3));
    next_cycle();
    bus.mgr_rvalid = 1'b1;
    @(negedge clk);
    chk("full pop rvalid", 64'(bus.sbr_rvalid), 64'(4'b0100));
    chk("full push req_o", 64'(bus.mgr_req), 64'(1));
    chk("full push gnt", 64'(bus.sbr_gnt), 64'(4'b1000));
    next_cycle();
    bus.sbr_req = 4'b0000;
    @(negedge clk);
    chk("push+pop outstanding", 64'(outstanding), 64'(3));
    chk("next rvalid", 64'(bus.sbr_rvalid), 64'(4'b0001));
    next_cycle();
    bus.mgr_rvalid = 1'b0;
    @(negedge clk);
    chk("pre-reset outstanding", 64'(outstanding), 64'(2));
    next_cycle();

    // ---- reset with 2 outstanding, then a late rvalid ----
    bus.sbr_req = 4'b0001;
    rst         = 1'b1;
    #2;
    chk("midrst outstanding", 64'(outstanding), 64'(0));
    chk("midrst req_o", 64'(bus.mgr_req), 64'(0));
`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
    chk("midrst spurious", 64'(spur), 64'(0));
`endif
    next_cycle();
    idle_inputs();
    rst            = 1'b0;
    bus.mgr_rvalid = 1'b1;
    @(negedge clk);
    chk("late rvalid dropped", 64'(bus.sbr_rvalid), 64'(0));
    chk("late rvalid outstanding", 64'(outstanding), 64'(0));
    next_cycle();
    bus.mgr_rvalid = 1'b0;
    @(negedge clk);
    chk("after late outstanding", 64'(outstanding), 64'(0));
`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
    chk("late rvalid spurious", 64'(spur), 64'(1));
`endif
    next_cycle();

    // ---- random traffic against a queue model ----
    do_reset();
    m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_spur = 0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = '0;
    end
    repeat (500) begin
      int  w;
      bit  any, full, pop, ero, hs, g, rv;
      logic [31:0] rd;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          pend[i]  = 1'b1;
          paddr[i] = $urandom() & 32'hFFFF_FFFC;
        end
        bus.sbr_req[i]  = pend[i];
        bus.sbr_addr[i] = paddr[i];
      end
      g  = ($urandom_range(0, 99) < 60);
      rv = (q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
      rd = $urandom();
      bus.mgr_gnt    = g;
      bus.mgr_rvalid = rv;
      bus.mgr_rdata  = rd;

      any  = 0;
      for (int i = 0; i < N; i++) any |= pend[i];
      full = (q.size() == D);
      pop  = rv && (q.size() > 0);
      w    = 0;
      if (m_lock && pend[m_lock_idx]) begin
        w = m_lock_idx;
      end else begin
        for (int k = N - 1; k >= 0; k--) if (pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      ero = any && (!full || pop);
      hs  = ero && g;

      @(negedge clk);
      chk("rnd req_o", 64'(bus.mgr_req), 64'(ero));
      if (ero) chk("rnd addr", 64'(bus.mgr_addr), 64'(paddr[w]));
      chk("rnd gnt", 64'(bus.sbr_gnt), hs ? 64'(1) << w : 64'(0));
      chk("rnd rvalid", 64'(bus.sbr_rvalid), pop ? 64'(1) << q[0] : 64'(0));
      chk("rnd outstanding", 64'(outstanding), 64'(q.size()));
      if (pop) chk("rnd rdata", 64'(bus.sbr_rdata[q[0]]), 64'(rd));
      next_cycle();

      if (rv && !pop) m_spur = 1;
      if (pop) void'(q.pop_front());
      if (hs) begin
        q.push_back(w);
        pend[w] = 1'b0;
        m_ptr   = (w + 1) % N;
        m_lock  = 0;
      end else if (ero) begin
        m_lock     = 1;
        m_lock_idx = w;
      end
    end
`ifdef OBI_MUX_RR_SPURIOUS_ERR_EN
    @(negedge clk);
    chk("rnd spurious", 64'(spur), 64'(m_spur));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
